// File: rtl/subbytes_sequencer.sv
// subbytes_sequencer
// Takes a 128-bit AES state over a valid/ready handshake and feeds it one byte
// per cycle into an external S-box stage with LAT cycles of latency. It then
// collects the 16 returned bytes and presents the reassembled result over a
// second valid/ready handshake.
module subbytes_sequencer #(
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_dec,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_dec,
  output logic [127:0] out_state,
  output logic         sb_dec,
  output logic [7:0]   sb_byte_out,
  input  logic [7:0]   sb_byte_in,
  output logic         busy
);

  // state | meaning
  // IDLE  | waiting for a state; in_ready high
  // FEED  | driving source bytes 0..15 to the S-box stage
  // DRAIN | feed finished, waiting for the last results to return
  // DONE  | result presented on out_state, waiting for out_ready
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [127:0] src_reg;
  logic [127:0] res_reg;
  logic         mode_reg;
  logic [3:0]   feed_cnt;
  logic [3:0]   cap_cnt;
  logic         accept;
  logic         issue;
  logic         capture;
  logic [6:0]   feed_base;
  logic [6:0]   cap_base;

  // Byte k lives at bits [127-8k -: 8], i.e. base 120-8k for an ascending part-select.
  assign feed_base = 7'd120 - {feed_cnt, 3'b000};
  assign cap_base  = 7'd120 - {cap_cnt, 3'b000};
  assign issue     = (state == FEED);

  // Capture is driven only by a tracked issue delayed by the stage latency.
  generate
    if (LAT == 0) begin : g_lat0
      assign capture = issue;
    end else begin : g_latn
      logic [LAT-1:0] issue_sr;

      // Issue tracker: one bit per byte in flight through the S-box stage.
      always_ff @(posedge clk) begin
        if (rst) begin
          issue_sr <= '0;
        end else begin
          issue_sr[0] <= issue;
          for (int i = 1; i < LAT; i++) begin
            issue_sr[i] <= issue_sr[i-1];
          end
        end
      end

      assign capture = issue_sr[LAT-1];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake/stage outputs.
  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    accept      = 1'b0;
    sb_byte_out = 8'h00;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        in_ready = !rst;
        accept   = in_valid && !rst;
        if (accept) begin
          state_nxt = FEED;
        end
      end
      FEED: begin
        sb_byte_out = src_reg[feed_base +: 8];
        if (feed_cnt == 4'd15) begin
          state_nxt = (LAT > 0) ? DRAIN : DONE;
        end
      end
      DRAIN: begin
        if (capture && (cap_cnt == 4'd15)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Source/result/mode registers and the feed and capture counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_reg  <= '0;
      res_reg  <= '0;
      mode_reg <= 1'b0;
      feed_cnt <= 4'd0;
      cap_cnt  <= 4'd0;
    end else begin
      if (accept) begin
        src_reg  <= in_state;
        mode_reg <= in_dec;
        feed_cnt <= 4'd0;
        cap_cnt  <= 4'd0;
      end
      // Counters saturate at 15 so they never wrap inside a block.
      if (issue && (feed_cnt != 4'd15)) begin
        feed_cnt <= feed_cnt + 4'd1;
      end
      if (capture) begin
        res_reg[cap_base +: 8] <= sb_byte_in;
        if (cap_cnt != 4'd15) begin
          cap_cnt <= cap_cnt + 4'd1;
        end
      end
    end
  end

  // Mode is only loaded on acceptance, so it stays fixed for the whole block.
  assign sb_dec    = mode_reg;
  assign out_dec   = mode_reg;
  assign out_state = res_reg;

endmodule

// File: tb/tb_subbytes_sequencer.sv
// Bench for subbytes_sequencer: two instances (LAT=1 and LAT=2), each fed by a
// behavioural S-box stage built from a GF(2^8) reference model.
module tb_subbytes_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid1, in_ready1, in_dec1, out_valid1, out_ready1, out_dec1, sb_dec1, busy1;
  logic [127:0] in_state1, out_state1;
  logic [7:0]   sb_out1, sb_in1;
  logic         in_valid2, in_ready2, in_dec2, out_valid2, out_ready2, out_dec2, sb_dec2, busy2;
  logic [127:0] in_state2, out_state2;
  logic [7:0]   sb_out2, sb_in2;

  subbytes_sequencer #(.LAT(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_dec(in_dec1), .in_state(in_state1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_dec(out_dec1), .out_state(out_state1),
    .sb_dec(sb_dec1), .sb_byte_out(sb_out1), .sb_byte_in(sb_in1), .busy(busy1)
  );

  subbytes_sequencer #(.LAT(2)) dut_l2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_dec(in_dec2), .in_state(in_state2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_dec(out_dec2), .out_state(out_state2),
    .sb_dec(sb_dec2), .sb_byte_out(sb_out2), .sb_byte_in(sb_in2), .busy(busy2)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int j = 1; j < 256; j++) begin
      if (gmul(x, 8'(j)) == 8'h01) inv = 8'(j);
    end
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_state(input logic [127:0] s, input logic dec);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      r[127-8*k -: 8] = dec ? inv_t[s[127-8*k -: 8]] : fwd_t[s[127-8*k -: 8]];
    end
    return r;
  endfunction

  // S-box stage models with one and two register stages of latency.
  logic [7:0] pipe1, pipe2a, pipe2b;
  always @(posedge clk) pipe1 <= sb_dec1 ? inv_t[sb_out1] : fwd_t[sb_out1];
  always @(posedge clk) begin
    pipe2a <= sb_dec2 ? inv_t[sb_out2] : fwd_t[sb_out2];
    pipe2b <= pipe2a;
  end
  assign sb_in1 = pipe1;
  assign sb_in2 = pipe2b;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard for the LAT=1 instance.
  logic [127:0] exp_next;
  logic         exp_dec_next;
  logic [128:0] exp_q [$];
  int           acc_q [$];
  int           n_acc = 0;
  logic         prev_valid1 = 1'b0;
  logic [128:0] mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid1 && in_ready1) begin
        acc_q.push_back(cyc + 1);
        exp_q.push_back({exp_dec_next, exp_next});
        n_acc++;
      end
      if (out_valid1 && !prev_valid1) begin
        if (acc_q.size() == 0) check("spurious_valid", out_valid1, 1'b0);
        else check("valid_latency", cyc - acc_q[0] + 1, 18);
      end
      if (out_valid1 && out_ready1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", out_valid1, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          void'(acc_q.pop_front());
          check("out_state", out_state1, mon_e[127:0]);
          check("out_dec", out_dec1, mon_e[128]);
        end
      end
    end
    prev_valid1 = out_valid1;
  end

  task automatic send_block(input logic [127:0] st, input logic dec, input logic [127:0] ex,
                            input bit keep, output int acc_at);
    in_state1 = st; in_dec1 = dec; exp_next = ex; exp_dec_next = dec; in_valid1 = 1'b1;
    acc_at = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (in_ready1) begin
        acc_at = cyc + 1;
        break;
      end
    end
    if (acc_at < 0) check("accept_timeout", in_ready1, 1'b1);
    @(posedge clk); #1;
    in_state1 = ~st; in_dec1 = ~dec;
    if (!keep) in_valid1 = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_rst_vals(input logic rdy);
    check("rst_in_ready", in_ready1, rdy);
    check("rst_out_valid", out_valid1, 1'b0);
    check("rst_out_state", out_state1, 128'h0);
    check("rst_out_dec", out_dec1, 1'b0);
    check("rst_sb_dec", sb_dec1, 1'b0);
    check("rst_sb_byte_out", sb_out1, 8'h00);
    check("rst_busy", busy1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] st, e;
    int acc, prev_acc, first_v, n_v, acc_before;

    rst = 1'b1;
    in_valid1 = 0; in_dec1 = 0; in_state1 = '0; out_ready1 = 0; exp_next = '0; exp_dec_next = 0;
    in_valid2 = 0; in_dec2 = 0; in_state2 = '0; out_ready2 = 0;
    for (int i = 0; i < 256; i++) fwd_t[i] = sbox_calc(8'(i));
    for (int i = 0; i < 256; i++) inv_t[fwd_t[i]] = 8'(i);

    // Reset values during and after reset.
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_rst_vals(1'b0);
    check("rst_in_ready_l2", in_ready2, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_rst_vals(1'b1);
    check("rst_in_ready_l2_after", in_ready2, 1'b1);
    @(posedge clk); #1;

    // SubBytes reference vector.
    out_ready1 = 1'b1;
    send_block(128'h000102030405060708090a0b0c0d0e0f, 1'b0,
               128'h637c777bf26b6fc53001672bfed7ab76, 1'b0, acc);
    wait_drain();

    // InvSubBytes reference vector; sb_dec and byte order during feed.
    st = 128'h637c777bf26b6fc53001672bfed7ab76;
    send_block(st, 1'b1, 128'h000102030405060708090a0b0c0d0e0f, 1'b0, acc);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("feed_sb_dec", sb_dec1, 1'b1);
      check("feed_byte", sb_out1, st[127-8*k -: 8]);
    end
    @(negedge clk);
    check("drain_byte_zero", sb_out1, 8'h00);
    @(posedge clk); #1;
    wait_drain();

    // LAT=2 instance, all-0x53 state.
    in_state2 = {16{8'h53}}; in_dec2 = 1'b0; in_valid2 = 1'b1;
    @(negedge clk);
    check("l2_in_ready", in_ready2, 1'b1);
    @(posedge clk); #1;
    in_valid2 = 1'b0; in_state2 = '1;
    first_v = 0;
    for (int m = 1; m <= 30; m++) begin
      @(negedge clk);
      check("l2_sb_byte", sb_out2, (m <= 16) ? 8'h53 : 8'h00);
      if (out_valid2) begin
        first_v = m;
        break;
      end
    end
    check("l2_valid_cycle", first_v, 19);
    check("l2_result", out_state2, {16{8'hed}});
    check("l2_dec", out_dec2, 1'b0);
    @(posedge clk); #1;
    out_ready2 = 1'b1;
    @(posedge clk); #1;
    out_ready2 = 1'b0;
    @(negedge clk);
    check("l2_idle_after", in_ready2, 1'b1);
    @(posedge clk); #1;

    // Backpressure: hold out_ready low for 10 cycles with in_valid offered.
    out_ready1 = 1'b0;
    st = {$urandom(), $urandom(), $urandom(), $urandom()};
    e = sub_state(st, 1'b0);
    send_block(st, 1'b0, e, 1'b0, acc);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_valid1) break;
    end
    check("stall_valid_seen", out_valid1, 1'b1);
    acc_before = n_acc;
    @(posedge clk); #1;
    in_valid1 = 1'b1; in_state1 = ~st;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("stall_state", out_state1, e);
      check("stall_in_ready", in_ready1, 1'b0);
      check("stall_valid", out_valid1, 1'b1);
      @(posedge clk); #1;
    end
    in_valid1 = 1'b0; out_ready1 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("release_idle", in_ready1, 1'b1);
    check("release_busy", busy1, 1'b0);
    check("stall_no_accept", n_acc, acc_before);
    @(posedge clk); #1;
    wait_drain();

    // Reset in cycle 8 of a block.
    st = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_block(st, 1'b1, sub_state(st, 1'b1), 1'b0, acc);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_in_ready", in_ready1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    acc_q.delete();
    exp_q.delete();
    @(negedge clk);
    check_rst_vals(1'b1);
    n_v = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (out_valid1) n_v++;
    end
    check("abort_no_valid", n_v, 0);
    @(posedge clk); #1;
    st = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_block(st, 1'b0, sub_state(st, 1'b0), 1'b0, acc);
    wait_drain();

    // Back-to-back with alternating mode.
    out_ready1 = 1'b1;
    prev_acc = 0;
    for (int i = 0; i < 4; i++) begin
      logic d;
      d = 1'(i % 2);
      st = {$urandom(), $urandom(), $urandom(), $urandom()};
      send_block(st, d, sub_state(st, d), 1'b1, acc);
      if (i > 0) check("b2b_spacing", acc - prev_acc, 19);
      prev_acc = acc;
    end
    in_valid1 = 1'b0;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
